// File: rtl/cordic_vec_seq.sv
// ----------------------------------------------------------------------------
// cordic_vec_seq
//
// Folded CORDIC vectoring engine. One (X,Y) vector is accepted, optionally
// pre-rotated by 180 degrees so that X is non-negative, and then driven toward
// the positive X axis by N_ITER shift-add micro-rotations. All the rotations
// share one stage datapath, and a small sequencer steps through them. The
// final X is the gain-scaled magnitude (K*|v|, K ~ 1.6468). The final Y is the
// residual. Each micro-rotation's direction is reported as one bit, so a
// downstream block can rebuild the phase. No 1/K compensation is applied here.
//
// Parameters
//   W        input sample width (signed two's complement)
//   N_ITER   number of micro-rotations, shift amounts 0..N_ITER-1 (2..16)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; aborts any run in progress
//   start      request, only honoured while ready=1
//   X_in       signed X sample, captured when start is accepted
//   Y_in       signed Y sample, captured when start is accepted
//   ready      high in IDLE and DONE (a new start will be accepted)
//   busy       high in PRE and ITER
//   valid_out  single-cycle pulse while in DONE
//   mag_out    signed final X (W+2 bits), held until the next DONE
//   y_res      signed final Y residual (W+2 bits), held until the next DONE
//   dir_bits   bit k = 1 when Y was >= 0 at iteration k, held until next DONE
// ----------------------------------------------------------------------------
module cordic_vec_seq #(
    parameter int W      = 15,
    parameter int N_ITER = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] X_in,
    input  logic signed [W-1:0] Y_in,
    output logic                ready,
    output logic                busy,
    output logic                valid_out,
    output logic signed [W+1:0] mag_out,
    output logic signed [W+1:0] y_res,
    output logic [N_ITER-1:0]   dir_bits
);

    // Two guard bits cover the CORDIC gain (K*sqrt(2) < 4). They also make
    // negating the most negative input sample safe.
    localparam int WI = W + 2;

    // The iteration counter only has to count up to N_ITER-1.
    localparam int KW = (N_ITER > 2) ? $clog2(N_ITER) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_ITER,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic signed [WI-1:0] x_q, x_d;
    logic signed [WI-1:0] y_q, y_d;
    logic [KW-1:0]        k_q, k_d;
    logic [N_ITER-1:0]    dir_work_q, dir_work_d;
    logic signed [WI-1:0] mag_q, mag_d;
    logic signed [WI-1:0] yres_q, yres_d;
    logic [N_ITER-1:0]    dir_q, dir_d;

    // Sign-extended copies of the input samples, used whenever a start is accepted.
    logic signed [WI-1:0] x_ext;
    logic signed [WI-1:0] y_ext;

    assign x_ext = {{2{X_in[W-1]}}, X_in};
    assign y_ext = {{2{Y_in[W-1]}}, Y_in};

    // ------------------------------------------------------------------------
    // Shared micro-rotation stage. The shifts are arithmetic, so each shifted
    // term rounds toward minus infinity. The adds wrap at WI bits. The guard
    // bits keep every legal input inside that range, so they never
    // actually wrap.
    // ------------------------------------------------------------------------
    logic signed [WI-1:0] x_shift;
    logic signed [WI-1:0] y_shift;
    logic signed [WI-1:0] x_rot;
    logic signed [WI-1:0] y_rot;
    logic                 y_nonneg;
    logic [N_ITER-1:0]    dir_upd;

    always_comb begin
        x_shift  = x_q >>> k_q;
        y_shift  = y_q >>> k_q;
        y_nonneg = ~y_q[WI-1];
        dir_upd  = dir_work_q;

        if (y_nonneg) begin
            x_rot = x_q + y_shift;
            y_rot = y_q - x_shift;
        end else begin
            x_rot = x_q - y_shift;
            y_rot = y_q + x_shift;
        end

        // Bits for iterations not yet reached keep their old values.
        dir_upd[k_q] = y_nonneg;
    end

    // ------------------------------------------------------------------------
    // Sequencer: next-state and datapath register loads.
    // The result registers load only on the last iteration. A run cut short
    // by reset therefore never shows on the outputs.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        k_d        = k_q;
        dir_work_d = dir_work_q;
        mag_d      = mag_q;
        yres_d     = yres_q;
        dir_d      = dir_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x_ext;
                    y_d     = y_ext;
                    state_d = S_PRE;
                end
            end

            S_PRE: begin
                // Rotating by 180 degrees moves a left-half-plane vector into
                // the right half plane. The vectoring iterations only converge
                // from there.
                if (x_q[WI-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                end
                k_d     = '0;
                state_d = S_ITER;
            end

            S_ITER: begin
                x_d        = x_rot;
                y_d        = y_rot;
                dir_work_d = dir_upd;
                if (k_q == K_LAST) begin
                    mag_d   = x_rot;
                    yres_d  = y_rot;
                    dir_d   = dir_upd;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            S_DONE: begin
                // A start seen here is taken right away, so back-to-back
                // vectors lose no cycle to IDLE.
                if (start) begin
                    x_d     = x_ext;
                    y_d     = y_ext;
                    state_d = S_PRE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers. Reset takes effect at once and clears
    // the result registers too. After an abort the outputs read all zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            k_q        <= '0;
            dir_work_q <= '0;
            mag_q      <= '0;
            yres_q     <= '0;
            dir_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            k_q        <= k_d;
            dir_work_q <= dir_work_d;
            mag_q      <= mag_d;
            yres_q     <= yres_d;
            dir_q      <= dir_d;
        end
    end

    // Handshake flags are decoded straight from the state register.
    assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy      = (state_q == S_PRE)  || (state_q == S_ITER);
    assign valid_out = (state_q == S_DONE);

    assign mag_out  = mag_q;
    assign y_res    = yres_q;
    assign dir_bits = dir_q;

endmodule

// File: tb/tb_cordic_vec_seq.sv
// ----------------------------------------------------------------------------
// tb_cordic_vec_seq
//
// Directed bench for the folded CORDIC vectoring engine (W=15, N_ITER=12).
// The driver issues vectors. Each expected magnitude, residual and direction
// word was worked out by hand, one iteration at a time, and the driver pushes
// it into a queue. A separate monitor pops one entry for every valid_out pulse
// and compares. It also checks the latency from the accepting edge, and the
// gap between consecutive results where a test asks for it.
// ----------------------------------------------------------------------------
module tb_cordic_vec_seq;

    localparam int W      = 15;
    localparam int N_ITER = 12;
    localparam int LAT    = N_ITER + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic                ready;
    logic                busy;
    logic                valid_out;
    logic signed [W+1:0] mag_out;
    logic signed [W+1:0] y_res;
    logic [N_ITER-1:0]   dir_bits;

    typedef struct {
        int mag;
        int yres;
        int dir;
        int issue_cyc;
        int gap;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_valid_cyc = -1;

    cordic_vec_seq #(
        .W      (W),
        .N_ITER (N_ITER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .X_in      (x_in),
        .Y_in      (y_in),
        .ready     (ready),
        .busy      (busy),
        .valid_out (valid_out),
        .mag_out   (mag_out),
        .y_res     (y_res),
        .dir_bits  (dir_bits)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // This counter holds the index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // One comparison. The arguments are 4-state, so X/Z on the DUT also miscompares.
    task automatic checkOutput(input string name, input logic signed [31:0] act,
                               input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Wait for ready, present the vector and hold start through one rising
    // edge. When hold is set, start is left high afterwards. When do_exp is
    // set, the expected result is queued, stamped with the accepting edge.
    task automatic applyStimulus(input int x, input int y, input bit hold, input bit do_exp,
                                 input int e_mag, input int e_yres, input int e_dir,
                                 input int e_gap);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL ready_timeout: ready=%0b after %0d cycles, expected 1", ready, waited);
            return;
        end
        x_in  = W'(x);
        y_in  = W'(y);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (do_exp) begin
            e.mag       = e_mag;
            e.yres      = e_yres;
            e.dir       = e_dir;
            e.issue_cyc = cyc;
            e.gap       = e_gap;
            sb.push_back(e);
        end
        checkOutput("busy_after_accept", busy, 1);
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Let all queued results come out, then idle a little longer so that any
    // stray valid_out pulse reaches the monitor.
    task automatic waitDrain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
        end
        repeat (20) @(negedge clk);
    endtask

    // Monitor: compare every result the DUT presents against the queue.
    always @(negedge clk) begin
        if (!rst && valid_out) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL unexpected_valid: got valid_out=1 with nothing pending, expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("mag_out", mag_out, mon_e.mag);
                checkOutput("y_res", y_res, mon_e.yres);
                checkOutput("dir_bits", dir_bits, mon_e.dir);
                checkOutput("latency", cyc - mon_e.issue_cyc, LAT);
                checkOutput("ready_in_done", ready, 1);
                checkOutput("busy_in_done", busy, 0);
                if (mon_e.gap > 0)
                    checkOutput("valid_gap", cyc - last_valid_cyc, mon_e.gap);
            end
            last_valid_cyc = cyc;
        end
    end

    // Safety net: the run must always end on its own.
    initial begin
        #2_000_000;
        n_err++;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_valid", valid_out, 0);
        checkOutput("reset_mag", mag_out, 0);
        checkOutput("reset_yres", y_res, 0);
        checkOutput("reset_dir", dir_bits, 0);
        rst = 1'b0;

        // Plain first-quadrant vector.
        $display("[TB] vector (3000,4000)");
        applyStimulus(3000, 4000, 0, 1, 8238, 3, 'h0D3, 0);
        waitDrain();

        // Left half plane takes the pre-rotation. Then comes the zero vector.
        $display("[TB] vector (-3000,4000) then (0,0)");
        applyStimulus(-3000, 4000, 0, 1, 8235, -3, 'hF2C, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 'hFFF, 0);
        waitDrain();

        // Most negative corner: the result needs the full 17-bit range.
        $display("[TB] vector (-16384,-16384)");
        applyStimulus(-16384, -16384, 0, 1, 38156, -5, 'hF83, 0);
        waitDrain();

        // Start pulses while busy must be ignored. The monitor flags any extra result.
        $display("[TB] start pulses during a run");
        applyStimulus(3000, 4000, 0, 1, 8238, 3, 'h0D3, 0);
        repeat (2) @(negedge clk);
        x_in  = 15'sd100;
        y_in  = -15'sd50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDrain();

        // Back-to-back: start stays high, and DONE takes the next vector.
        $display("[TB] back-to-back vectors");
        applyStimulus(3000, 4000, 1, 1, 8238, 3, 'h0D3, 0);
        applyStimulus(1000, 0, 0, 1, 1649, 0, 'h8D1, N_ITER + 2);
        waitDrain();

        // Asynchronous reset mid-ITER (k=5) aborts without a result.
        $display("[TB] reset mid-run");
        applyStimulus(3000, 4000, 0, 0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);
        checkOutput("busy_before_abort", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_ready", ready, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_valid", valid_out, 0);
        checkOutput("abort_mag", mag_out, 0);
        checkOutput("abort_yres", y_res, 0);
        checkOutput("abort_dir", dir_bits, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("idle_after_abort", ready, 1);

        // A normal run must follow the abort.
        applyStimulus(3000, 4000, 0, 1, 8238, 3, 'h0D3, 0);
        waitDrain();

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL leftover_results: %0d pending, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
